// File: rtl/adder_tree_loader_pkg.sv
// rtl/adder_tree_loader_pkg.sv - shared types and helpers for the adder tree loader
package adder_tree_loader_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    FILL,
    WAIT,
    DONE
  } loader_state_e;

  // Bit offset of slot k within the packed tree input bus.
  function automatic int slot_off(input int k);
    return k * WORD_W;
  endfunction

endpackage

// File: rtl/adder_tree_lat_timer.sv
// rtl/adder_tree_lat_timer.sv - latency timer, cleared on start, done while count equals LAT
module adder_tree_lat_timer #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic done
);

  localparam int TW = $clog2(LAT + 2);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      count <= '0;
    end else if (en) begin
      count <= count + TW'(1);
    end
  end

  assign done = (count == TW'(LAT));

endmodule

// File: rtl/adder_tree_loader.sv
// rtl/adder_tree_loader.sv - packs N stream words into the adder tree and captures its sum
module adder_tree_loader
  import adder_tree_loader_pkg::*;
#(
  parameter int N   = 2,
  parameter int LAT = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [WORD_W*N-1:0]   tree_in,
  input  logic [WORD_W-1:0]     tree_out,
  output logic [WORD_W-1:0]     m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy
);

  localparam int CW = $clog2(N);

  loader_state_e state, state_d;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_accept;
  logic          capture;
  logic          out_hs;
  logic          timer_done;

  assign accept      = s_valid && s_ready;
  assign last_accept = accept && (cnt == CW'(N - 1));
  assign busy        = (state != FILL) || (cnt != '0);

  always_comb begin
    state_d = state;
    s_ready = 1'b0;
    capture = 1'b0;
    out_hs  = 1'b0;
    case (state)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid && (cnt == CW'(N - 1))) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (timer_done) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (m_valid && m_ready) begin
          out_hs  = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  adder_tree_lat_timer #(
    .LAT(LAT)
  ) u_lat_timer (
    .clk  (clk),
    .rst  (rst),
    .start(last_accept),
    .en   (state == WAIT),
    .done (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      cnt     <= '0;
      tree_in <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        cnt <= last_accept ? '0 : cnt + CW'(1);
      end
      // Slots are only overwritten, never cleared; every frame rewrites all of them.
      for (int k = 0; k < N; k++) begin
        if (accept && (cnt == CW'(k))) begin
          tree_in[slot_off(k) +: WORD_W] <= s_data;
        end
      end
      if (capture) begin
        m_data  <= tree_out;
        m_valid <= 1'b1;
      end else if (out_hs) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
